sum_alarm_monitor: RTL
======================

# sum_alarm_monitor

Downstream consumer of the 4-sample running-sum stage. Takes its 10-bit sum (range 0..1020) and produces a registered average, a peak-hold value, and a debounced, hysteretic over-level alarm with an event counter. One instance sits behind each running-sum stage and drives the status/indicator logic.

## Interface
- HI_TH, 800: alarm-set threshold; a qualifying sample has sum >= HI_TH.
- LO_TH, 400: alarm-clear threshold; a qualifying sample has sum <= LO_TH. Constraint: LO_TH < HI_TH <= 1020.
- DEBOUNCE, 3: number of consecutive qualifying samples needed to change alarm state. Legal range 1..15.

Ports:
- clk  input  1  clock, rising-edge active.
- reset  input  1  asynchronous, active-low. One clock; reset is asynchronous and active-low.
- sum  input  10  running sum from the upstream stage.
- en  input  1  sample-valid; `sum` is consumed only on edges where en=1.
- clear  input  1  synchronous clear of the peak and event counter.
- avg  output  8  registered sum>>2.
- peak  output  10  maximum sum sampled since reset or the last clear.
- alarm  output  1  debounced alarm level.
- alarm_cnt  output  8  number of alarm rising events, saturating at 255.
- state  output  2  FSM state: NORMAL=0, PEND_HI=1, ALARM=2, PEND_LO=3.

## Operation
- Samples with en=0 are ignored. FSM state, debounce counter, avg and peak all hold.
- avg <= sum[9:2] (truncating) on every en edge.
- peak <= max(peak, sum) on every en edge. Compare is 10-bit unsigned.
- The debounce counter is 4-bit. It counts consecutive qualifying en samples and returns to 0 on every state change or non-qualifying sample.
- FSM transitions, evaluated on en edges only:
  - NORMAL: if sum >= HI_TH, count = 1.
    - If DEBOUNCE==1, go directly to ALARM.
    - Otherwise go to PEND_HI.
  - PEND_HI:
    - If sum >= HI_TH, increment the count. When the count reaches DEBOUNCE, go to ALARM.
    - If sum < HI_TH, go to NORMAL.
  - ALARM: if sum <= LO_TH, go to PEND_LO (or to NORMAL if DEBOUNCE==1).
  - PEND_LO:
    - If sum <= LO_TH, increment the count. When the count reaches DEBOUNCE, go to NORMAL.
    - If sum > LO_TH, go back to ALARM.
- alarm = 1 in ALARM and PEND_LO; alarm = 0 in NORMAL and PEND_HI. alarm is registered, decoded from the next state.
- alarm_cnt increments on each transition into ALARM from PEND_HI or NORMAL. A return from PEND_LO to ALARM does not count. alarm_cnt saturates at 255.
- clear=1 (synchronous): peak <= 0 and alarm_cnt <= 0. The FSM, counter and avg are unaffected.
- clear and en in the same cycle:
  - peak <= sum, so the new window starts with this sample.
  - If the same edge enters ALARM, alarm_cnt <= 1; otherwise alarm_cnt <= 0.

## Timing
- While reset=0, asynchronously: avg=0, peak=0, alarm=0, alarm_cnt=0, state=NORMAL, counter=0.
- Reset released mid-operation: the block restarts from NORMAL. Any partial debounce progress is lost.
- Latency: one clock from an en sample to avg and peak.
- alarm rises on the edge that captures the DEBOUNCE-th consecutive sample >= HI_TH.
- alarm falls on the edge that captures the DEBOUNCE-th consecutive sample <= LO_TH.
- No combinational path exists from any input to any output.
- en gaps do not break a consecutive run. Consecutiveness counts en samples, not clocks.
- Boundary comparisons:
  - sum == HI_TH qualifies as high.
  - sum == LO_TH qualifies as low.
  - sum == 1020 gives avg = 255.
  - Values between LO_TH and HI_TH hold the current alarm level.

## Test plan
All scenarios use the default parameters: HI_TH=800, LO_TH=400, DEBOUNCE=3.
- Reset: reset=0 with arbitrary inputs -> all outputs 0 and state=0. Release reset, then en with sum=100 -> avg=25, peak=100, alarm=0.
- Alarm set: en with sum=1020 for 3 samples -> state 1,1,2 after each edge. alarm=1 after the 3rd edge; avg=255, peak=1020, alarm_cnt=1.
- Debounce reject: from NORMAL, sum=850, 850, 700 -> state 1,1,0; alarm stays 0; alarm_cnt unchanged; peak=850.
- Hysteresis, starting in ALARM:
  - 20 samples of 500 -> alarm stays 1.
  - Then 400, 300, 450 -> state 3,3,2; alarm stays 1.
  - Then 400, 400, 400 -> alarm=0 after the 3rd edge, state=0.
- en gaps and boundary:
  - Sequence 800, en=0 for 2 clocks, 800, 800 -> alarm rises on the 3rd en edge, not before.
  - Sum=799 never qualifies.
- Async reset mid-PEND_HI and clear collision:
  - reset pulse while in state 1 -> immediate zeros; next two high samples do not raise alarm.
  - clear with en, sum=900, completing a debounce run -> peak=900, alarm_cnt=1.
  - 256 alarm cycles -> alarm_cnt stays 255.

Source files
------------

// File: rtl/sum_alarm_monitor.sv
// Averages, peak-holds and alarms on the 10-bit output of a 4-sample running-sum stage.
// The over-level alarm is debounced in both directions and has hysteresis between the two thresholds.
module sum_alarm_monitor #(
    parameter int unsigned HI_TH    = 800,
    parameter int unsigned LO_TH    = 400,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] sum,
    input  logic       en,
    input  logic       clear,
    output logic [7:0] avg,
    output logic [9:0] peak,
    output logic       alarm,
    output logic [7:0] alarm_cnt,
    output logic [1:0] state
);

    localparam int unsigned SUM_W = 10;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned EVT_W = 8;

    localparam logic [SUM_W-1:0] HI_LVL  = SUM_W'(HI_TH);
    localparam logic [SUM_W-1:0] LO_LVL  = SUM_W'(LO_TH);
    localparam logic [CNT_W-1:0] DEB_LEN = CNT_W'(DEBOUNCE);
    localparam logic [EVT_W-1:0] EVT_MAX = '1;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        PEND_HI = 2'd1,
        ALARM   = 2'd2,
        PEND_LO = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] deb_q;
    logic [CNT_W-1:0] deb_d;
    logic [CNT_W-1:0] deb_inc;
    logic             enter_alarm;
    logic             is_hi;
    logic             is_lo;
    logic             alarm_d;

    assign is_hi   = (sum >= HI_LVL);
    assign is_lo   = (sum <= LO_LVL);
    assign deb_inc = CNT_W'(deb_q + CNT_W'(1));

    // Debounce / hysteresis next-state; nothing moves on clocks without en.
    always_comb begin
        state_d     = state_q;
        deb_d       = deb_q;
        enter_alarm = 1'b0;
        if (en) begin
            unique case (state_q)
                NORMAL: begin
                    if (is_hi) begin
                        if (DEB_LEN == CNT_W'(1)) begin
                            state_d     = ALARM;
                            deb_d       = '0;
                            enter_alarm = 1'b1;
                        end else begin
                            state_d = PEND_HI;
                            deb_d   = CNT_W'(1);
                        end
                    end else begin
                        deb_d = '0;
                    end
                end
                PEND_HI: begin
                    if (is_hi) begin
                        if (deb_inc == DEB_LEN) begin
                            state_d     = ALARM;
                            deb_d       = '0;
                            enter_alarm = 1'b1;
                        end else begin
                            deb_d = deb_inc;
                        end
                    end else begin
                        state_d = NORMAL;
                        deb_d   = '0;
                    end
                end
                ALARM: begin
                    if (is_lo) begin
                        if (DEB_LEN == CNT_W'(1)) begin
                            state_d = NORMAL;
                            deb_d   = '0;
                        end else begin
                            state_d = PEND_LO;
                            deb_d   = CNT_W'(1);
                        end
                    end else begin
                        deb_d = '0;
                    end
                end
                PEND_LO: begin
                    if (is_lo) begin
                        if (deb_inc == DEB_LEN) begin
                            state_d = NORMAL;
                            deb_d   = '0;
                        end else begin
                            deb_d = deb_inc;
                        end
                    end else begin
                        state_d = ALARM;
                        deb_d   = '0;
                    end
                end
                default: begin
                    state_d = NORMAL;
                    deb_d   = '0;
                end
            endcase
        end
    end

    assign alarm_d = (state_d == ALARM) || (state_d == PEND_LO);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= NORMAL;
            deb_q   <= '0;
            alarm   <= 1'b0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            alarm   <= alarm_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            avg <= '0;
        end else if (en) begin
            avg <= sum[9:2];
        end
    end

    // A clear that coincides with a sample opens the new peak window with that sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak <= '0;
        end else if (clear) begin
            peak <= en ? sum : '0;
        end else if (en && (sum > peak)) begin
            peak <= sum;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarm_cnt <= '0;
        end else if (clear) begin
            alarm_cnt <= enter_alarm ? EVT_W'(1) : '0;
        end else if (enter_alarm && (alarm_cnt != EVT_MAX)) begin
            alarm_cnt <= EVT_W'(alarm_cnt + EVT_W'(1));
        end
    end

    assign state = state_q;

endmodule
